// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for serial_subtractor.
// The overflow signal exists only when SERIAL_SUB_SIGNED_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] answer;
  logic             borrow_out;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             overflow;
`endif

  modport master (
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    input  overflow,
`endif
    output in_valid, input1, input2, out_ready,
    input  in_ready, out_valid, answer, borrow_out
  );

  modport slave (
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output overflow,
`endif
    input  in_valid, input1, input2, out_ready,
    output in_ready, out_valid, answer, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: answer = input1 - input2, CHUNK bits per clock, LSB first.
// Define SERIAL_SUB_SIGNED_OVF_EN to add a registered two's-complement overflow output.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic            clk,
  input logic            rst_n,
  serial_subtractor_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("serial_subtractor: CHUNK must divide WIDTH exactly");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] answer_q, answer_d;
  logic             borrow_out_q, borrow_out_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;

  logic [CHUNK:0]   diff;
  logic [WIDTH-1:0] r_next;
  logic             last_chunk;

  // One chunk of the ripple: the extra MSB of the CHUNK+1-bit difference is the borrow.
  assign diff       = {1'b0, a_sr_q[CHUNK-1:0]} - {1'b0, b_sr_q[CHUNK-1:0]}
                    - {{CHUNK{1'b0}}, borrow_q};
  assign r_next     = (r_sr_q >> CHUNK) | (WIDTH'(diff[CHUNK-1:0]) << (WIDTH - CHUNK));
  assign last_chunk = (count_q == CW'(NCH - 1));

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic ovf_q, ovf_d;
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    count_d      = count_q;
    borrow_d     = borrow_q;
    answer_d     = answer_q;
    borrow_out_d = borrow_out_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    r_sr_d       = r_sr_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ovf_d        = ovf_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sr_d   = bus.input1;
          b_sr_d   = bus.input2;
          borrow_d = 1'b0;
          count_d  = '0;
          state_d  = BUSY;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          a_msb_d  = bus.input1[WIDTH-1];
          b_msb_d  = bus.input2[WIDTH-1];
`endif
        end
      end
      BUSY: begin
        a_sr_d   = a_sr_q >> CHUNK;
        b_sr_d   = b_sr_q >> CHUNK;
        r_sr_d   = r_next;
        borrow_d = diff[CHUNK];
        count_d  = count_q + CW'(1);
        if (last_chunk) begin
          answer_d     = r_next;
          borrow_out_d = diff[CHUNK];
          state_d      = DONE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          ovf_d        = (a_msb_q != b_msb_q) && (r_next[WIDTH-1] != a_msb_q);
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      borrow_q     <= 1'b0;
      answer_q     <= '0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      borrow_q     <= borrow_d;
      answer_q     <= answer_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  // NOTE: operand/result shift registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    a_sr_q <= a_sr_d;
    b_sr_q <= b_sr_d;
    r_sr_q <= r_sr_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    a_msb_q <= a_msb_d;
    b_msb_q <= b_msb_d;
`endif
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.answer     = answer_q;
  assign bus.borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign bus.overflow   = ovf_q;
`endif
endmodule
